// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of mem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives the ports.
// Parameters must match the ADDR_W/DATA_W of the attached mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    // load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // single-port memory
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_wr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_wr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of one single-port memory.
// Latency: gnt in T, mem access in T+1, rvalid in T+2+MEM_LAT, re-arbitrate at T+3+MEM_LAT.
// Backpressure: requesters hold req until gnt; requests are only looked at in IDLE.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          res,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              sel_d_q, sel_d_d;     // 1: data port owns the current access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_gnt_c, d_gnt_c, pick_d;

    // Arbitration, access sequencing and read-data capture.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        starve_d  = starve_q;
        sel_d_d   = sel_d_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_gnt_c   = 1'b0;
        d_gnt_c   = 1'b0;
        pick_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.i_req) begin
                    starve_d = '0;
                end
                if (bus.i_req || bus.d_req) begin
                    // Data wins ties unless the fetch port has already lost STARVE_MAX times.
                    pick_d  = bus.d_req && !(bus.i_req && (starve_q == SW'(STARVE_MAX)));
                    state_d = ISSUE;
                    if (pick_d) begin
                        d_gnt_c = 1'b1;
                        sel_d_d = 1'b1;
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        if (bus.i_req && (starve_q != SW'(STARVE_MAX))) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        i_gnt_c  = 1'b1;
                        sel_d_d  = 1'b0;
                        we_d     = 1'b0;
                        addr_d   = bus.i_addr;
                        starve_d = '0;
                    end
                end
            end
            ISSUE: begin
                wcnt_d  = 3'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == 3'(MEM_LAT - 1)) begin
                    wcnt_d  = 3'd0;
                    state_d = DONE;
                    // Stores leave the owner's read register untouched.
                    if (!we_q) begin
                        if (sel_d_q) d_rdata_d = bus.mem_rdata;
                        else         i_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clock or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            wcnt_q    <= 3'd0;
            starve_q  <= '0;
            sel_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            starve_q  <= starve_d;
            sel_d_q   <= sel_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Grants are combinational from IDLE, so they are masked while reset is held.
    assign bus.i_gnt     = i_gnt_c & res;
    assign bus.d_gnt     = d_gnt_c & res;
    assign bus.i_rvalid  = (state_q == DONE) && !sel_d_q;
    assign bus.d_rvalid  = (state_q == DONE) &&  sel_d_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr    = (state_q == ISSUE) && we_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have parameter MEM_LAT, default 1 (legal range 1..7), the number of cycles from the ISSUE cycle until mem_rdata is valid.
REQ-004 The block SHALL have parameter STARVE_MAX, default 4, the number of consecutive data grants allowed while the instruction port waits.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 res  in  1  reset, asynchronous, active-low.
REQ-007 i_req  in  1  instruction-fetch request, level.
REQ-008 i_addr  in  ADDR_W  fetch address.
REQ-009 i_gnt  out  1  one-cycle grant pulse to the fetch port.
REQ-010 i_rvalid  out  1  one-cycle completion pulse to the fetch port.
REQ-011 i_rdata  out  DATA_W  fetched word, registered.
REQ-012 d_req  in  1  data-port (load/store) request, level.
REQ-013 d_we  in  1  data-port write enable: 1 = store, 0 = load.
REQ-014 d_addr  in  ADDR_W  data address.
REQ-015 d_wdata  in  DATA_W  store data.
REQ-016 d_gnt  out  1  one-cycle grant pulse to the data port.
REQ-017 d_rvalid  out  1  one-cycle completion pulse to the data port.
REQ-018 d_rdata  out  DATA_W  load data, registered.
REQ-019 mem_addr  out  ADDR_W  address to the single-port memory.
REQ-020 mem_wr  out  1  memory write strobe.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_rdata  in  DATA_W  memory read data.
REQ-023 busy  out  1  high whenever state != IDLE.

Function
REQ-024 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; ISSUE and DONE SHALL each last exactly 1 cycle, and WAIT SHALL last exactly MEM_LAT cycles, counted by an internal counter.
REQ-025 Arbitration SHALL occur only in IDLE: if any request is high, the winner's gnt SHALL pulse in that cycle, its addr/we/wdata SHALL be latched at that edge, and the FSM SHALL go to ISSUE.
REQ-026 Priority SHALL go to the data port when both ports request, except as defined in REQ-027.
REQ-027 A starve counter SHALL increment on each data grant made while i_req=1, and SHALL clear on any instruction grant or on any IDLE cycle with i_req=0; when the counter equals STARVE_MAX and both ports request, the instruction port SHALL win.
REQ-028 In ISSUE, mem_wr SHALL equal the latched we; mem_wr SHALL be 0 in every other state, combinationally decoded from state.
REQ-029 mem_addr and mem_wdata SHALL present the latched values from ISSUE through DONE and SHALL hold their last value while in IDLE.
REQ-030 On the last WAIT cycle edge, the winner's rdata register SHALL capture mem_rdata on a load and SHALL remain unchanged on a store.
REQ-031 In DONE, the winner's rvalid SHALL pulse for 1 cycle for both loads and stores, and the FSM SHALL then return to IDLE.
REQ-032 Latency: gnt in cycle T, ISSUE in T+1, rvalid in T+2+MEM_LAT, next arbitration no earlier than T+3+MEM_LAT.
REQ-033 Handshake: a requester SHALL hold req, addr, we and wdata stable until it sees gnt; req still high in IDLE after a completion SHALL be treated as a new request; dropping req before gnt (withdrawal) SHALL be legal and SHALL produce no gnt.
REQ-034 Requests arriving while busy=1 SHALL be ignored until IDLE; gnt and rvalid SHALL never be asserted to both ports in the same cycle.

Reset
REQ-035 While res=0, the block SHALL be held as follows, independent of clock:
- state = IDLE;
- starve counter and wait counter = 0;
- all gnt, rvalid and mem_wr outputs = 0;
- mem_addr, mem_wdata, i_rdata and d_rdata = 0;
- busy = 0.
REQ-036 Reset mid-operation SHALL abandon the access: no rvalid pulse SHALL follow, and after release the first request SHALL be serviced per REQ-032.

Verification
REQ-037 Fetch read (MEM_LAT=1): i_req=1, i_addr=0x10 in cycle 0, memory returns 0xDEADBEEF -> i_gnt in cycle 0; mem_addr=0x10 and mem_wr=0 in cycle 1; i_rvalid in cycle 3 with i_rdata=0xDEADBEEF.
REQ-038 Collision: i_req and d_req both high in cycle 0, held -> d_gnt in cycle 0, d_rvalid in cycle 3, i_gnt in cycle 4, i_rvalid in cycle 7.
REQ-039 Store: d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_wr=1 only in cycle 1 with mem_wdata=0x12345678; d_rvalid in cycle 3; d_rdata unchanged.
REQ-040 Starvation (STARVE_MAX=2): both requests held continuously -> grant order D, D, I, D, D, I.
REQ-041 Reset in WAIT: res=0 in cycle 2 of a load -> mem_wr=0, busy=0, no d_rvalid; a new i_req after release yields i_gnt in the first IDLE cycle and i_rvalid MEM_LAT+2 cycles later.
REQ-042 Withdrawal: d busy, i_req pulsed for 1 cycle then dropped before returning to IDLE -> i_gnt never asserted.
